// File: rtl/alarm_clock_multi_pkg.sv
// Shared types and helpers for the multi-alarm clock.
// Provides the alarm FSM state enum, the packed alarm record, the modulo
// constants for each time field, and the digit -> 7-segment lookup
// (bit0 = segment a, active-high) together with a binary -> BCD splitter.
package alarm_clk_pkg;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} fsm_e;

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
  } alarm_t;

  localparam int SEC_PER_MIN = 60;
  localparam int MIN_PER_HR  = 60;
  localparam int HR_PER_DAY  = 24;
  localparam int DAYS        = 7;

  // Segment order is {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG7_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Non-decimal codes blank the digit rather than showing garbage.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    seg7 = (d < 4'd10) ? SEG7_TABLE[d] : 7'h00;
  endfunction

  // Returns {tens, ones} for values 0..59.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    to_bcd = {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

endpackage

// File: rtl/alarm_clock_multi_if.sv
// Control and display bundle of the alarm clock.
// master: board/bench side; drives buttons and switches, reads display/buzzer.
// slave : clock core side; reads buttons and switches, drives display/buzzer.
//  Timeset/Alarmset    edit-mode selects (Timeset has priority)
//  Minadv/Hrsadv/Dayadv per-Pulse field advance levels
//  AlarmSel/AlarmEn    alarm being edited / per-alarm enables
//  Alarmon/Snooze/Mode24 master enable, snooze request, 24-hour display
//  S1..H0disp, DayLED, AMorPM, Buzz, RingIdx  outputs
interface alarm_clock_multi_if #(
  parameter int NUM_ALARMS = 4
);
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  Timeset;
  logic                  Alarmset;
  logic                  Minadv;
  logic                  Hrsadv;
  logic                  Dayadv;
  logic [AW-1:0]         AlarmSel;
  logic [NUM_ALARMS-1:0] AlarmEn;
  logic                  Alarmon;
  logic                  Snooze;
  logic                  Mode24;

  logic [6:0]            S1disp;
  logic [6:0]            S0disp;
  logic [6:0]            M1disp;
  logic [6:0]            M0disp;
  logic [6:0]            H1disp;
  logic [6:0]            H0disp;
  logic [6:0]            DayLED;
  logic                  AMorPM;
  logic                  Buzz;
  logic [AW-1:0]         RingIdx;

  modport master (
    output Timeset, Alarmset, Minadv, Hrsadv, Dayadv, AlarmSel, AlarmEn,
           Alarmon, Snooze, Mode24,
    input  S1disp, S0disp, M1disp, M0disp, H1disp, H0disp, DayLED, AMorPM,
           Buzz, RingIdx
  );

  modport slave (
    input  Timeset, Alarmset, Minadv, Hrsadv, Dayadv, AlarmSel, AlarmEn,
           Alarmon, Snooze, Mode24,
    output S1disp, S0disp, M1disp, M0disp, H1disp, H0disp, DayLED, AMorPM,
           Buzz, RingIdx
  );

endinterface

// File: rtl/alarm_clock_multi_ct.sv
// Modulo-N counter used for each time field.
//  clk      counting clock (one edge per second)
//  rst_n    asynchronous active-low reset to 0
//  clr      synchronous clear, dominates inc
//  inc      advance by one this edge (wraps N-1 -> 0)
//  nocarry  suppresses carry so a manual edit does not ripple upward
//  count    current value
//  carry    high when this edge wraps the counter
module ct_mod_n #(
  parameter  int N = 60,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         nocarry,
  output logic [W-1:0] count,
  output logic         carry
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  assign carry = inc & ~clr & ~nocarry & (count == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clr)    count <= '0;
    else if (inc)    count <= (count == MAX) ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/alarm_clock_multi.sv
// Board-level top of the multi-alarm clock.
// Keeps sec/min/hr/weekday on the 1 Hz Pulse, holds NUM_ALARMS alarm times,
// runs the IDLE/RING/SNOOZE alarm FSM and drives six 7-segment digits,
// weekday LEDs, AM/PM and the buzzer.
//  Pulse    clock, one rising edge per second
//  Reset_n  asynchronous active-low reset
//  bus      control inputs and display outputs (slave side)
module alarm_clock_multi
  import alarm_clk_pkg::*;
#(
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_MIN   = 9,
  parameter int RING_MAX_SEC = 60
) (
  input  logic                Pulse,
  input  logic                Reset_n,
  alarm_clock_multi_if.slave  bus
);

  localparam int          AW          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam logic [11:0] RING_LAST   = 12'(RING_MAX_SEC - 1);
  localparam logic [11:0] SNOOZE_LAST = 12'(SNOOZE_MIN * 60 - 1);

  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic [2:0] day;
  logic       sec_carry;
  logic       min_carry;
  logic       hr_carry;
  logic       unused_day_carry;

  logic       time_edit;
  logic       alarm_edit;

  assign time_edit  = bus.Timeset;
  assign alarm_edit = bus.Alarmset & ~bus.Timeset;

  // While setting time the seconds sit at zero and each field advances on its
  // own button with carries suppressed; otherwise the chain ripples normally.
  ct_mod_n #(.N(SEC_PER_MIN)) u_sec (
    .clk(Pulse), .rst_n(Reset_n), .clr(time_edit), .inc(1'b1),
    .nocarry(time_edit), .count(sec), .carry(sec_carry)
  );

  ct_mod_n #(.N(MIN_PER_HR)) u_min (
    .clk(Pulse), .rst_n(Reset_n), .clr(1'b0),
    .inc(time_edit ? bus.Minadv : sec_carry),
    .nocarry(time_edit), .count(min), .carry(min_carry)
  );

  ct_mod_n #(.N(HR_PER_DAY)) u_hr (
    .clk(Pulse), .rst_n(Reset_n), .clr(1'b0),
    .inc(time_edit ? bus.Hrsadv : min_carry),
    .nocarry(time_edit), .count(hr), .carry(hr_carry)
  );

  ct_mod_n #(.N(DAYS)) u_day (
    .clk(Pulse), .rst_n(Reset_n), .clr(1'b0),
    .inc(time_edit ? bus.Dayadv : hr_carry),
    .nocarry(time_edit), .count(day), .carry(unused_day_carry)
  );

  // Alarm registers; only the selected one is edited, fields wrap independently.
  alarm_t alarms [NUM_ALARMS];

  always_ff @(posedge Pulse or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) alarms[i] <= '0;
    end else if (alarm_edit) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (bus.AlarmSel == AW'(i)) begin
          if (bus.Minadv)
            alarms[i].min <= (alarms[i].min == 6'd59) ? 6'd0 : alarms[i].min + 6'd1;
          if (bus.Hrsadv)
            alarms[i].hr <= (alarms[i].hr == 5'd23) ? 5'd0 : alarms[i].hr + 5'd1;
        end
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  logic          any_match;
  logic [AW-1:0] winner;

  always_comb begin
    any_match = 1'b0;
    winner    = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (bus.AlarmEn[i] && alarms[i].hr == hr && alarms[i].min == min) begin
        any_match = 1'b1;
        winner    = AW'(i);
      end
    end
    if (!(bus.Alarmon && sec == 6'd0 && !bus.Timeset && !bus.Alarmset))
      any_match = 1'b0;
  end

  // One counter serves both the ring timeout and the snooze delay.
  fsm_e          state;
  fsm_e          state_nxt;
  logic [11:0]   cnt;
  logic [11:0]   cnt_nxt;
  logic [AW-1:0] ring_idx;
  logic [AW-1:0] ring_idx_nxt;
  logic          ring_ok;

  always_ff @(posedge Pulse or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ring_idx <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ring_idx <= ring_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ring_idx_nxt = ring_idx;
    ring_ok      = bus.Alarmon & bus.AlarmEn[ring_idx];
    case (state)
      IDLE: begin
        if (any_match) begin
          state_nxt    = RING;
          ring_idx_nxt = winner;
          cnt_nxt      = '0;
        end
      end
      RING: begin
        if (!ring_ok) begin
          state_nxt = IDLE;
        end else if (bus.Snooze) begin
          state_nxt = SNOOZE;
          cnt_nxt   = '0;
        end else if (cnt == RING_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 12'd1;
        end
      end
      SNOOZE: begin
        if (!ring_ok) begin
          state_nxt = IDLE;
        end else if (cnt == SNOOZE_LAST) begin
          state_nxt = RING;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 12'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Display source: the edited alarm (seconds blank to 00) or the running time,
  // then optional 12-hour remap where hour 0 reads as 12 AM.
  logic [4:0] disp_hr;
  logic [4:0] show_hr;
  logic [5:0] disp_min;
  logic [5:0] disp_sec;
  logic       pm;
  logic [7:0] h_bcd;
  logic [7:0] m_bcd;
  logic [7:0] s_bcd;

  always_comb begin
    disp_hr  = hr;
    disp_min = min;
    disp_sec = sec;
    if (alarm_edit) begin
      disp_hr  = alarms[bus.AlarmSel].hr;
      disp_min = alarms[bus.AlarmSel].min;
      disp_sec = '0;
    end
    pm      = 1'b0;
    show_hr = disp_hr;
    if (!bus.Mode24) begin
      pm = (disp_hr >= 5'd12);
      if (disp_hr == 5'd0)       show_hr = 5'd12;
      else if (disp_hr > 5'd12)  show_hr = disp_hr - 5'd12;
    end
    h_bcd = to_bcd({1'b0, show_hr});
    m_bcd = to_bcd(disp_min);
    s_bcd = to_bcd(disp_sec);
  end

  assign bus.H1disp  = seg7(h_bcd[7:4]);
  assign bus.H0disp  = seg7(h_bcd[3:0]);
  assign bus.M1disp  = seg7(m_bcd[7:4]);
  assign bus.M0disp  = seg7(m_bcd[3:0]);
  assign bus.S1disp  = seg7(s_bcd[7:4]);
  assign bus.S0disp  = seg7(s_bcd[3:0]);
  assign bus.DayLED  = 7'd1 << day;
  assign bus.AMorPM  = pm;
  assign bus.Buzz    = (state == RING);
  assign bus.RingIdx = ring_idx;

endmodule
